// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default
// latencies and the controller state encoding.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    localparam int MDU_MULT_CYC = 5;
    localparam int MDU_DIV_CYC  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational datapath: produces the {HI, LO} pair for a
// mult/multu/div/divu and flags a divide by zero.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_r,
    output logic [31:0] lo_r,
    output logic        div0
);

    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic        [31:0] w_bsafe;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquo;
    logic        [31:0] w_urem;
    logic               w_ovf;

    assign w_smul  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul  = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by 1 so the dividers never see it; the
    // result is discarded at commit anyway.
    assign w_bsafe = (b == 32'd0) ? 32'd1 : b;
    assign w_squo  = $signed(a) / $signed(w_bsafe);
    assign w_srem  = $signed(a) % $signed(w_bsafe);
    assign w_uquo  = a / w_bsafe;
    assign w_urem  = a % w_bsafe;

    // The one signed quotient that does not fit: -2^31 / -1.
    assign w_ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Select the result pair for the requested op.
    always_comb begin
        hi_r = 32'd0;
        lo_r = 32'd0;
        div0 = 1'b0;
        case (op)
            MDU_MULT: begin
                hi_r = w_smul[63:32];
                lo_r = w_smul[31:0];
            end
            MDU_MULTU: begin
                hi_r = w_umul[63:32];
                lo_r = w_umul[31:0];
            end
            MDU_DIV: begin
                div0 = (b == 32'd0);
                if (w_ovf) begin
                    hi_r = 32'd0;
                    lo_r = 32'h8000_0000;
                end else begin
                    hi_r = w_srem;
                    lo_r = w_squo;
                end
            end
            MDU_DIVU: begin
                div0 = (b == 32'd0);
                hi_r = w_urem;
                lo_r = w_uquo;
            end
            default: begin
                hi_r = 32'd0;
                lo_r = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the E stage. Accepts an op,
// holds its result pending for a fixed latency, then commits to HI/LO.
// start|busy feed the hazard unit's stall logic.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MDU_MULT_CYC,
    parameter int DIV_CYC  = MDU_DIV_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rsel,
    output logic        start,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYC);

    mdu_state_e  r_state;
    logic        r_busy;
    logic [3:0]  r_count;
    logic [31:0] r_hi_p;
    logic [31:0] r_lo_p;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_hi_r;
    logic [31:0] w_lo_r;
    logic        w_div0;
    logic        w_is_mt;
    logic        w_go;
    logic        w_start;
    logic        w_is_mul;

    mdu_arith u_arith (
        .op   (op),
        .a    (A),
        .b    (B),
        .hi_r (w_hi_r),
        .lo_r (w_lo_r),
        .div0 (w_div0)
    );

    // Acceptance gating: cancel or an in-flight op blocks every E effect,
    // so start cannot rise without req.
    assign w_is_mt  = (op == MDU_MTHI) || (op == MDU_MTLO);
    assign w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
    assign w_go     = req & ~cancel & ~r_busy & (is_muldiv(op) | w_is_mt);
    assign w_start  = w_go & is_muldiv(op);

    assign start = w_start;
    assign busy  = r_busy;
    assign HI    = r_hi;
    assign LO    = r_lo;
    assign rdata = rsel ? r_hi : r_lo;

    // Controller FSM: latch the result on acceptance, count down, commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_count <= 4'd0;
            r_hi_p  <= 32'd0;
            r_lo_p  <= 32'd0;
            r_div0  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_count <= w_is_mul ? LP_MULT_CNT : LP_DIV_CNT;
                        r_hi_p  <= w_hi_r;
                        r_lo_p  <= w_lo_r;
                        r_div0  <= w_div0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else if (w_go) begin
                        if (op == MDU_MTHI) begin
                            r_hi <= A;
                        end else begin
                            r_lo <= A;
                        end
                    end
                end
                ST_RUN: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        // A divide by zero runs its full length but leaves HI/LO alone.
                        if (!r_div0) begin
                            r_hi <= r_hi_p;
                            r_lo <= r_lo_p;
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed results, busy lengths,
// cancel/reset behaviour and back-to-back issue spacing.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] A;
    logic [31:0] B;
    logic        rsel;
    logic        start;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_cyc = 0;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .op     (op),
        .cancel (cancel),
        .A      (A),
        .B      (B),
        .rsel   (rsel),
        .start  (start),
        .busy   (busy),
        .rdata  (rdata),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stall source must stay quiet without a request; req must never arrive while busy.
    always @(negedge clk) begin
        if (!reset && !req) chk("start_no_req", {31'd0, start}, 32'd0);
        if (!reset && req && busy) chk("req_while_busy", 32'd1, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one cycle, check start, then count busy cycles.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic c, input logic exp_start,
                          input int exp_busy);
        int n;
        req = 1'b1; op = o; A = a; B = b; cancel = c;
        #1;
        chk({tag, "_start"}, {31'd0, start}, {31'd0, exp_start});
        start_cyc = cyc;
        step();
        req = 1'b0; op = 3'd0; cancel = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
        $display("op %s a=%h b=%h busy=%0d HI=%h LO=%h", tag, a, b, n, HI, LO);
    endtask

    initial begin
        int t0;
        reset = 1'b1; req = 1'b0; op = 3'd0; cancel = 1'b0;
        A = 32'd0; B = 32'd0; rsel = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFE);

        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 5);
        chk("multu_hi", HI, 32'd1);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 10);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("div_lo", LO, 32'hFFFF_FFFD);

        run_op("divu0", 3'd4, 32'd7, 32'd0, 1'b0, 1'b1, 10);
        chk("divu0_hi", HI, 32'hFFFF_FFFF);
        chk("divu0_lo", LO, 32'hFFFF_FFFD);

        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 10);
        chk("ovf_hi", HI, 32'd0);
        chk("ovf_lo", LO, 32'h8000_0000);

        run_op("mthi", 3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 0);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_lo", LO, 32'h8000_0000);
        rsel = 1'b1; #1;
        chk("mfhi", rdata, 32'h1234_5678);
        rsel = 1'b0; #1;
        chk("mflo", rdata, 32'h8000_0000);

        run_op("mtlo", 3'd6, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0, 0);
        chk("mtlo_lo", LO, 32'hCAFE_0001);
        chk("mtlo_rd", rdata, 32'hCAFE_0001);

        run_op("mult_cancel", 3'd1, 32'd3, 32'd3, 1'b1, 1'b0, 0);
        chk("cancel_hi", HI, 32'h1234_5678);
        chk("cancel_lo", LO, 32'hCAFE_0001);

        // Cancel in T+2 of an accepted mult must not abort it.
        req = 1'b1; op = 3'd1; A = 32'd3; B = 32'd5;
        #1;
        chk("mc_start", {31'd0, start}, 32'd1);
        step();                                  // T+1
        req = 1'b0; op = 3'd0;
        step();                                  // T+2
        cancel = 1'b1;
        step();                                  // T+3
        cancel = 1'b0;
        step();                                  // T+4
        step();                                  // T+5
        chk("mc_busy_t5", {31'd0, busy}, 32'd1);
        chk("mc_lo_t5", LO, 32'hCAFE_0001);
        step();                                  // T+6
        chk("mc_busy_t6", {31'd0, busy}, 32'd0);
        chk("mc_lo_t6", LO, 32'd15);
        chk("mc_hi_t6", HI, 32'd0);
        $display("op mult_then_cancel a=3 b=5 HI=%h LO=%h", HI, LO);

        // Reset in the third busy cycle of a div discards it.
        req = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
        #1;
        chk("rd_start", {31'd0, start}, 32'd1);
        step();                                  // T+1
        req = 1'b0; op = 3'd0;
        step();                                  // T+2
        step();                                  // T+3
        reset = 1'b1;
        step();                                  // T+4
        reset = 1'b0;
        chk("rd_busy", {31'd0, busy}, 32'd0);
        chk("rd_hi", HI, 32'd0);
        chk("rd_lo", LO, 32'd0);
        $display("op reset_mid_div HI=%h LO=%h busy=%0d", HI, LO, busy);
        run_op("mult34", 3'd1, 32'd3, 32'd4, 1'b0, 1'b1, 5);
        chk("m34_lo", LO, 32'd12);
        chk("m34_hi", HI, 32'd0);

        // Back-to-back: div issued as soon as the mult's busy drops.
        run_op("b2b_mult", 3'd1, 32'd2, 32'd3, 1'b0, 1'b1, 5);
        t0 = start_cyc;
        chk("b2b_mult_lo", LO, 32'd6);
        run_op("b2b_div", 3'd4, 32'd100, 32'd7, 1'b0, 1'b1, 10);
        chk("b2b_gap", 32'(start_cyc - t0), 32'd6);
        chk("b2b_div_lo", LO, 32'd14);
        chk("b2b_div_hi", HI, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on run time in case the DUT wedges.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
